// File: rtl/fec_block_framer.sv
// fec_block_framer: splits payload bytes into SYM_W-bit symbols and frames each block with CRC, zero pad and an idle gap.
// Define FEC_BLOCK_FRAMER_CRC_EN to build the CRC-16/CCITT-FALSE generator; otherwise the CRC slots carry zeros.
module fec_block_framer #(
   parameter int SYM_W      = 4,
   parameter int DATA_BYTES = 238,
   parameter int INFO_BYTES = 240,
   parameter int GAP        = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       idat,
   input  logic             ival,
   output logic             ordy,
   output logic [SYM_W-1:0] odat,
   output logic             oval,
   input  logic             ireq,
   output logic             osop,
   output logic             oeop,
   output logic             obusy
);

   localparam int NSYM = 8 / SYM_W;
   localparam int SIW  = (NSYM > 1) ? $clog2(NSYM) : 1;
   localparam int BCW  = $clog2(INFO_BYTES + 1);
   localparam int GCW  = (GAP > 0) ? $clog2(GAP + 1) : 1;
   localparam bit HAS_PAD = (INFO_BYTES > DATA_BYTES + 2);

   localparam logic [SIW-1:0] SLAST  = SIW'(NSYM - 1);
   localparam logic [BCW-1:0] B_DATA = BCW'(DATA_BYTES);
   localparam logic [BCW-1:0] B_CRC1 = BCW'(DATA_BYTES + 1);
   localparam logic [BCW-1:0] B_INFO = BCW'(INFO_BYTES);
   localparam logic [GCW-1:0] G_LAST = GCW'((GAP > 0) ? GAP - 1 : 0);

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_DATA = 3'd1;
   localparam logic [2:0] ST_CRC  = 3'd2;
   localparam logic [2:0] ST_PAD  = 3'd3;
   localparam logic [2:0] ST_GAP  = 3'd4;

   logic [2:0]     state, nstate;
   logic [7:0]     sreg;
   logic [SIW-1:0] sidx;
   logic           full;
   logic [BCW-1:0] bcnt;
   logic [GCW-1:0] gcnt;
   logic           rdy_en;
   logic           xfer, last_xfer, acc;
   logic           ld, blk_end;
   logic [7:0]     ld_byte;
   logic [7:0]     crc_hi, crc_lo;

   assign xfer      = full & ireq;
   assign last_xfer = xfer & (sidx == SLAST);
   // bcnt counts bytes loaded, so it doubles as the payload limit
   assign ordy      = rdy_en
                    & ((state == ST_IDLE) | (state == ST_DATA))
                    & (~full | last_xfer)
                    & (bcnt < B_DATA);
   assign acc       = ival & ordy;

   assign odat  = sreg[7 -: SYM_W];
   assign oval  = full;
   assign osop  = full & (sidx == '0) & (bcnt == BCW'(1));
   assign oeop  = full & (sidx == SLAST) & (bcnt == B_INFO);
   assign obusy = (state != ST_IDLE);

`ifdef FEC_BLOCK_FRAMER_CRC_EN
   logic [15:0] crc;

   function automatic logic [15:0] crc_upd(input logic [15:0] c,
                                           input logic [7:0]  d);
      logic [15:0] r;
      r = c ^ {d, 8'h00};
      for (int i = 0; i < 8; i++)
         r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
      return r;
   endfunction

   // first byte of a block reseeds the register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         crc <= 16'hFFFF;
      else if (acc)
         crc <= crc_upd((state == ST_IDLE) ? 16'hFFFF : crc, idat);
   end

   assign crc_hi = crc[15:8];
   assign crc_lo = crc[7:0];
`else
   assign crc_hi = 8'h00;
   assign crc_lo = 8'h00;
`endif

   // internal bytes load as the previous byte's last symbol leaves
   always_comb begin
      ld      = 1'b0;
      ld_byte = idat;
      blk_end = 1'b0;
      nstate  = state;
      if (acc) begin
         ld = 1'b1;
         if (state == ST_IDLE)
            nstate = ST_DATA;
      end else if (last_xfer) begin
         unique case (1'b1)
            (state == ST_DATA): begin
               if (bcnt == B_DATA) begin
                  ld      = 1'b1;
                  ld_byte = crc_hi;
                  nstate  = ST_CRC;
               end
            end
            (state == ST_CRC): begin
               if (bcnt == B_CRC1) begin
                  ld      = 1'b1;
                  ld_byte = crc_lo;
               end else if (HAS_PAD) begin
                  ld      = 1'b1;
                  ld_byte = 8'h00;
                  nstate  = ST_PAD;
               end else begin
                  blk_end = 1'b1;
               end
            end
            (state == ST_PAD): begin
               if (bcnt == B_INFO) begin
                  blk_end = 1'b1;
               end else begin
                  ld      = 1'b1;
                  ld_byte = 8'h00;
               end
            end
            default: ;
         endcase
      end else if (state == ST_GAP && gcnt == G_LAST) begin
         nstate = ST_IDLE;
      end
      if (blk_end)
         nstate = (GAP == 0) ? ST_IDLE : ST_GAP;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= ST_IDLE;
         sreg   <= '0;
         sidx   <= '0;
         full   <= 1'b0;
         bcnt   <= '0;
         gcnt   <= '0;
         rdy_en <= 1'b0;
      end else begin
         state  <= nstate;
         rdy_en <= 1'b1;
         gcnt   <= (state == ST_GAP) ? gcnt + GCW'(1) : '0;
         if (ld) begin
            sreg <= ld_byte;
            sidx <= '0;
            full <= 1'b1;
            bcnt <= bcnt + BCW'(1);
         end else if (xfer) begin
            if (sidx == SLAST) begin
               sreg <= '0;
               sidx <= '0;
               full <= 1'b0;
            end else begin
               sreg <= sreg << SYM_W;
               sidx <= sidx + SIW'(1);
            end
         end
         if (blk_end)
            bcnt <= '0;
      end
   end

endmodule
